// File: rtl/mod_fetch_ctrl_pkg.sv
// Shared core defines for the fetch controller: FSM state encodings,
// reset vector default, instruction/address widths, PC alignment helper.
package mod_fetch_ctrl_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/mod_fetch_ctrl_if.sv
// Fetch bundle: redirect input, imem request/response, IF->ID buffer.
// master = fetch controller side, slave = memory/decode/branch side.
interface mod_fetch_ctrl_if;
  import mod_fetch_ctrl_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [ILEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus_4;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output if_valid, if_instr,
    output if_pc, if_pc_plus_4,
    input  if_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  if_valid, if_instr,
    input  if_pc, if_pc_plus_4,
    output if_ready
  );

endinterface

// File: rtl/mod_fetch_buf.sv
// One-entry instruction buffer. Ports: clk, rst_n, load/clear controls,
// instr_in/pc_in write data, valid/instr/pc/pc_plus_4 held contents.
module mod_fetch_buf
  import mod_fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [ILEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_4
);

  // clear only drops valid; data is kept so holds cost no muxing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      instr     <= '0;
      pc        <= '0;
      pc_plus_4 <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      instr     <= instr_in;
      pc        <= pc_in;
      pc_plus_4 <= pc_in + 32'd4;
    end
  end

endmodule

// File: rtl/mod_fetch_ctrl.sv
// Fetch controller: BOOT/RUN/DRAIN FSM, fetch PC, redirect handling.
// Ports: clk, rst_n, bus (mod_fetch_ctrl_if.master); with
// FETCH_CTRL_PERF_EN defined also perf_fetch_cnt, perf_redirect_cnt.
module mod_fetch_ctrl
  import mod_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic clk,
  input  logic rst_n,
  mod_fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] redir_pc;
  logic            req;
  logic            fire;
  logic            consume;
  logic            buf_load;
  logic            buf_clear;
  logic            buf_valid;
  logic [ILEN-1:0] buf_instr;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] buf_pc4;

  assign redir_pc = word_align(bus.redirect_pc);

  // A request in flight always finds the buffer empty (it was
  // empty or consumed when issued), so the empty term covers it.
  always_comb begin
    req = 1'b0;
    case (state)
      S_RUN:   req = !buf_valid || bus.if_ready;
      S_DRAIN: req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  assign fire      = req && bus.imem_ack;
  assign consume   = buf_valid && bus.if_ready;
  assign buf_load  = (state == S_RUN) && fire
                   && !bus.redirect_valid;
  assign buf_clear = bus.redirect_valid
                   || (consume && !buf_load);

  assign bus.imem_req     = req;
  assign bus.imem_addr    = fetch_pc;
  assign bus.if_valid     = buf_valid;
  assign bus.if_instr     = buf_instr;
  assign bus.if_pc        = buf_pc;
  assign bus.if_pc_plus_4 = buf_pc4;

  // fetch_pc doubles as the held address while draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      fetch_pc <= RESET_VECTOR;
      pend_pc  <= '0;
    end else begin
      unique case (state)
        S_BOOT: begin
          state <= S_RUN;
          if (bus.redirect_valid) fetch_pc <= redir_pc;
        end
        S_RUN: begin
          if (bus.redirect_valid) begin
            if (req && !bus.imem_ack) begin
              state   <= S_DRAIN;
              pend_pc <= redir_pc;
            end else begin
              fetch_pc <= redir_pc;
            end
          end else if (fire) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        S_DRAIN: begin
          if (bus.imem_ack) begin
            state    <= S_RUN;
            fetch_pc <= bus.redirect_valid
                      ? redir_pc : pend_pc;
          end else if (bus.redirect_valid) begin
            pend_pc <= redir_pc;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  mod_fetch_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .clear     (buf_clear),
    .instr_in  (bus.imem_rdata),
    .pc_in     (fetch_pc),
    .valid     (buf_valid),
    .instr     (buf_instr),
    .pc        (buf_pc),
    .pc_plus_4 (buf_pc4)
  );

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (consume)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (bus.redirect_valid)
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_fetch_ctrl.sv
// Self-checking bench for mod_fetch_ctrl: directed vector table,
// reset/perf sequences, randomized run against a queue-based model.
module tb_mod_fetch_ctrl;
  import mod_fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod_fetch_ctrl_if bus();

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] pf;
  logic [31:0] pr;
`endif

  mod_fetch_ctrl #(.RESET_VECTOR(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetch_cnt    (pf),
    .perf_redirect_cnt (pr)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return a * 32'd7 + 32'h1234_5679;
  endfunction

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        ack;
    logic        e_req;
    logic        e_v;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] in_b,
                              input logic [31:0] rpc,
                              input logic [1:0] ex_b,
                              input logic [31:0] eaddr,
                              input logic [31:0] epc);
    vec_t v;
    v.rd = in_b[2];
    v.rdy = in_b[1];
    v.ack = in_b[0];
    v.rpc = rpc;
    v.e_req = ex_b[1];
    v.e_v = ex_b[0];
    v.e_addr = eaddr;
    v.e_pc = epc;
    return v;
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  task automatic drive(input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic ack,
                       input logic [31:0] rdata);
    bus.redirect_valid = rd;
    bus.redirect_pc = rpc;
    bus.if_ready = rdy;
    bus.imem_ack = ack;
    bus.imem_rdata = rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[22];

  // random-phase model state
  logic        m_boot;
  logic        m_busy;
  logic        m_stale;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  ent_t        mq[$];
  logic [31:0] m_pf;
  logic [31:0] m_pr;

  initial begin
    tbl[0]  = mk(3'b011, 32'h0, 2'b00, 32'h0, 32'h0);
    tbl[1]  = mk(3'b011, 32'h0, 2'b10, 32'h0, 32'h0);
    tbl[2]  = mk(3'b011, 32'h0, 2'b11, 32'h4, 32'h0);
    tbl[3]  = mk(3'b011, 32'h0, 2'b11, 32'h8, 32'h4);
    tbl[4]  = mk(3'b001, 32'h0, 2'b01, 32'hC, 32'h8);
    tbl[5]  = mk(3'b000, 32'h0, 2'b01, 32'hC, 32'h8);
    tbl[6]  = mk(3'b000, 32'h0, 2'b01, 32'hC, 32'h8);
    tbl[7]  = mk(3'b011, 32'h0, 2'b11, 32'hC, 32'h8);
    tbl[8]  = mk(3'b000, 32'h0, 2'b01, 32'h10, 32'hC);
    tbl[9]  = mk(3'b100, 32'h103, 2'b01, 32'h10, 32'hC);
    tbl[10] = mk(3'b000, 32'h0, 2'b10, 32'h100, 32'h0);
    tbl[11] = mk(3'b100, 32'h200, 2'b10, 32'h100, 32'h0);
    tbl[12] = mk(3'b100, 32'h300, 2'b10, 32'h100, 32'h0);
    tbl[13] = mk(3'b001, 32'h0, 2'b10, 32'h100, 32'h0);
    tbl[14] = mk(3'b011, 32'h0, 2'b10, 32'h300, 32'h0);
    tbl[15] = mk(3'b010, 32'h0, 2'b11, 32'h304, 32'h300);
    tbl[16] = mk(3'b000, 32'h0, 2'b10, 32'h304, 32'h0);
    tbl[17] = mk(3'b001, 32'h0, 2'b10, 32'h304, 32'h0);
    tbl[18] = mk(3'b100, 32'hFFFF_FFFF, 2'b01,
                 32'h308, 32'h304);
    tbl[19] = mk(3'b011, 32'h0, 2'b10, 32'hFFFF_FFFC, 32'h0);
    tbl[20] = mk(3'b011, 32'h0, 2'b11, 32'h0, 32'hFFFF_FFFC);
    tbl[21] = mk(3'b011, 32'h0, 2'b11, 32'h4, 32'h0);

    // ---- directed table, starting in the boot cycle ----
    do_reset();
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rd, tbl[i].rpc, tbl[i].rdy, tbl[i].ack,
            mem_word(bus.imem_addr));
      #1;
      chk($sformatf("t%0d_req", i), {31'b0, bus.imem_req},
          {31'b0, tbl[i].e_req});
      chk($sformatf("t%0d_addr", i), bus.imem_addr,
          tbl[i].e_addr);
      chk($sformatf("t%0d_valid", i), {31'b0, bus.if_valid},
          {31'b0, tbl[i].e_v});
      if (tbl[i].e_v) begin
        chk($sformatf("t%0d_pc", i), bus.if_pc, tbl[i].e_pc);
        chk($sformatf("t%0d_instr", i), bus.if_instr,
            mem_word(tbl[i].e_pc));
        chk($sformatf("t%0d_pc4", i), bus.if_pc_plus_4,
            tbl[i].e_pc + 32'd4);
      end
      @(posedge clk);
      @(negedge clk);
    end

    // ---- reset in the middle of an outstanding request ----
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("pre_rst_req", {31'b0, bus.imem_req}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'b0, bus.imem_req}, 32'h0);
    chk("async_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("async_addr", bus.imem_addr, 32'h0);
    chk("async_pc", bus.if_pc, 32'h0);
    chk("async_instr", bus.if_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_c1_req", {31'b0, bus.imem_req}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rel_c2_req", {31'b0, bus.imem_req}, 32'h1);
    chk("rel_c2_addr", bus.imem_addr, 32'h0);

`ifdef FETCH_CTRL_PERF_EN
    // ---- performance counters: 10 accepts, 2 redirects ----
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, mem_word(bus.imem_addr));
      @(posedge clk);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("perf_fetch", pf, 32'd10);
    chk("perf_redir", pr, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("perf_fetch_rst", pf, 32'd0);
    chk("perf_redir_rst", pr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // ---- randomized run against the reference model ----
    do_reset();
    m_boot = 1'b1;
    m_busy = 1'b0;
    m_stale = 1'b0;
    m_pc = 32'h0;
    m_tgt = 32'h0;
    mq.delete();
    m_pf = 32'h0;
    m_pr = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      logic        rd, rdy, ack, e_req, fire;
      logic [31:0] rpc, rdata;
      rd = (i > 0) && ($urandom_range(7) == 0);
      rpc = $urandom;
      rdy = $urandom_range(3) != 0;
      ack = $urandom_range(2) != 0;
      rdata = $urandom;
      drive(rd, rpc, rdy, ack, rdata);
      e_req = !m_boot && (m_busy || mq.size() == 0 || rdy);
      #1;
      chk("r_req", {31'b0, bus.imem_req}, {31'b0, e_req});
      chk("r_addr", bus.imem_addr, m_pc);
      chk("r_valid", {31'b0, bus.if_valid},
          {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("r_pc", bus.if_pc, mq[0].pc);
        chk("r_instr", bus.if_instr, mq[0].instr);
        chk("r_pc4", bus.if_pc_plus_4, mq[0].pc + 32'd4);
      end
      @(posedge clk);
      if (mq.size() != 0 && rdy) m_pf = m_pf + 32'd1;
      if (rd) m_pr = m_pr + 32'd1;
      if (m_boot) begin
        m_boot = 1'b0;
        if (rd) m_pc = word_align(rpc);
      end else begin
        fire = e_req && ack;
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (rd) begin
          mq.delete();
          if (e_req && !ack) begin
            m_busy = 1'b1;
            m_stale = 1'b1;
            m_tgt = word_align(rpc);
          end else begin
            m_busy = 1'b0;
            m_stale = 1'b0;
            m_pc = word_align(rpc);
          end
        end else if (fire) begin
          if (m_stale) begin
            m_pc = m_tgt;
          end else begin
            mq.push_back('{rdata, m_pc});
            m_pc = m_pc + 32'd4;
          end
          m_busy = 1'b0;
          m_stale = 1'b0;
        end else if (e_req) begin
          m_busy = 1'b1;
        end
      end
      @(negedge clk);
    end
`ifdef FETCH_CTRL_PERF_EN
    #1;
    chk("r_perf_fetch", pf, m_pf);
    chk("r_perf_redir", pr, m_pr);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
